// File: rtl/router_out_reader_pkg.sv
// Shared definitions for the router output-port reader: packet field layout,
// reassembly FSM states and the buffered beat format.
package router_out_reader_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 2;
    localparam int LEN_MSB   = 7;
    localparam int LEN_LSB   = ADDR_W;
    localparam int LEN_W     = LEN_MSB - LEN_LSB + 1;
    localparam int STALL_W   = 5;
    localparam int STALL_MAX = 31;

    typedef enum logic [1:0] {
        S_HDR = 2'd0,
        S_PLD = 2'd1,
        S_PAR = 2'd2
    } state_e;

    typedef struct packed {
        logic              first;
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
        return hdr[LEN_MSB:LEN_LSB];
    endfunction

endpackage

// File: rtl/router_skid_buf.sv
// Two-entry FIFO of tagged beats between the FIFO read port and the sink.
// Flush wins over push and pop; the head reads as zero while empty.
module router_skid_buf
    import router_out_reader_pkg::*;
(
    input  logic       clock_i,
    input  logic       resetn_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic       flush_i,
    input  beat_t      din_i,
    output beat_t      head_o,
    output logic [1:0] occ_o
);

    localparam logic [1:0] FULL = 2'd2;

    beat_t      mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] occ_q;
    logic       do_pop;
    logic       do_push;

    assign do_pop  = pop_i && (occ_q != 2'd0);
    assign do_push = push_i && ((occ_q != FULL) || do_pop);

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= !wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            occ_q <= occ_q + 2'(do_push) - 2'(do_pop);
        end
    end

    // Storage needs no reset: the head is masked whenever occupancy is zero.
    always_ff @(posedge clock_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign head_o = (occ_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
    assign occ_o  = occ_q;

endmodule

// File: rtl/router_out_reader.sv
// Drains one router output FIFO, reassembles header/payload/parity beats,
// checks parity and forwards tagged bytes to a valid/ready sink.
module router_out_reader
    import router_out_reader_pkg::*;
#(
    parameter int STALL_WARN = 25,
    parameter int BUF_DEPTH  = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              vld_out,
    input  logic [DATA_W-1:0] data_out,
    input  logic              soft_reset,
    output logic              read_enb,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_first,
    output logic              m_last,
    output logic              parity_err,
    output logic              pkt_done,
    output logic              abort,
    output logic              stall_warn,
    output state_e            dbg_state_o
);

    // Sink handshake: a byte transfers on every rising edge where
    // m_valid && m_ready; m_valid and the head beat hold until that edge.

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]  par_q, par_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               run_q;
    logic               inflight_q;
    logic               pkt_done_q, pkt_done_d;
    logic               parity_err_q, parity_err_d;
    logic               abort_q, abort_d;

    beat_t              head;
    beat_t              push_beat;
    logic [1:0]         occ;
    logic [2:0]         pending;
    logic               pop;
    logic               capture;

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid && m_ready;
    assign capture = inflight_q && !soft_reset;

    // Slots already claimed after this edge: held beats plus the byte in
    // flight, less the one the sink takes now. run_q keeps reads off in reset.
    assign pending  = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign read_enb = run_q && vld_out && !soft_reset && (pending < 3'(BUF_DEPTH));

    router_skid_buf u_buf (
        .clock_i  (clock),
        .resetn_i (resetn),
        .push_i   (capture),
        .pop_i    (pop),
        .flush_i  (soft_reset),
        .din_i    (push_beat),
        .head_o   (head),
        .occ_o    (occ)
    );

    always_comb begin
        state_d         = state_q;
        rem_d           = rem_q;
        par_d           = par_q;
        pkt_done_d      = 1'b0;
        parity_err_d    = 1'b0;
        abort_d         = 1'b0;
        push_beat.first = 1'b0;
        push_beat.last  = 1'b0;
        push_beat.data  = data_out;

        if (soft_reset) begin
            state_d = S_HDR;
            rem_d   = '0;
            par_d   = '0;
            abort_d = (state_q != S_HDR) || (occ != 2'd0);
        end else if (capture) begin
            case (state_q)
                S_HDR: begin
                    push_beat.first = 1'b1;
                    rem_d           = hdr_len(data_out);
                    par_d           = data_out;
                    state_d         = (hdr_len(data_out) == '0) ? S_PAR : S_PLD;
                end
                S_PLD: begin
                    par_d = par_q ^ data_out;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_PAR;
                    end
                end
                S_PAR: begin
                    push_beat.last = 1'b1;
                    pkt_done_d     = 1'b1;
                    parity_err_d   = (data_out != par_q);
                    state_d        = S_HDR;
                end
                default: begin
                    state_d = S_HDR;
                end
            endcase
        end
    end

    always_comb begin
        stall_d = '0;
        if (vld_out && !read_enb) begin
            stall_d = (stall_q == STALL_W'(STALL_MAX)) ? stall_q : stall_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_HDR;
            rem_q        <= '0;
            par_q        <= '0;
            stall_q      <= '0;
            run_q        <= 1'b0;
            inflight_q   <= 1'b0;
            pkt_done_q   <= 1'b0;
            parity_err_q <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            par_q        <= par_d;
            stall_q      <= stall_d;
            run_q        <= 1'b1;
            inflight_q   <= read_enb;
            pkt_done_q   <= pkt_done_d;
            parity_err_q <= parity_err_d;
            abort_q      <= abort_d;
        end
    end

    assign m_data      = head.data;
    assign m_first     = head.first;
    assign m_last      = head.last;
    assign pkt_done    = pkt_done_q;
    assign parity_err  = parity_err_q;
    assign abort       = abort_q;
    assign stall_warn  = (int'(stall_q) >= STALL_WARN);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_router_out_reader.sv
// Directed and randomized checks of router_out_reader against a packet-level
// model: a source FIFO queue feeds data_out, a scoreboard queue holds beats.
module tb_router_out_reader;
    import router_out_reader_pkg::*;

    logic       clock = 1'b0;
    logic       resetn;
    logic       vld_out;
    logic [7:0] data_out;
    logic       soft_reset;
    logic       read_enb;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_first;
    logic       m_last;
    logic       parity_err;
    logic       pkt_done;
    logic       abort;
    logic       stall_warn;
    state_e     dbg_state;

    always #5 clock = ~clock;

    router_out_reader dut (
        .clock       (clock),
        .resetn      (resetn),
        .vld_out     (vld_out),
        .data_out    (data_out),
        .soft_reset  (soft_reset),
        .read_enb    (read_enb),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_first     (m_first),
        .m_last      (m_last),
        .parity_err  (parity_err),
        .pkt_done    (pkt_done),
        .abort       (abort),
        .stall_warn  (stall_warn),
        .dbg_state_o (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] exp_q[$];
    logic [7:0] src_q[$];
    logic [7:0] pl_q[$];

    int   cyc = 0;
    bit   re_s = 0;
    bit   prev_hold = 0;
    bit   prev_sr = 0;
    logic [9:0] prev_head;
    bit   mon_valid, mon_abort, saw_pld;
    int   cnt_done = 0, cnt_err = 0, cnt_abort = 0;
    int   exp_done = 0, exp_err = 0;
    int   pop_cnt = 0, first_pop_cyc, last_pop_cyc, first_re_cyc, done_cyc;
    int   base_pop, base_done, base_err, base_abort;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic mark();
        first_pop_cyc = -1;
        first_re_cyc  = -1;
        last_pop_cyc  = -1;
        done_cyc      = -1;
        saw_pld       = 0;
        base_pop      = pop_cnt;
        base_done     = cnt_done;
        base_err      = cnt_err;
        base_abort    = cnt_abort;
    endtask

    // One clock: observe at the falling edge, then model the source FIFO.
    task automatic step();
        logic [9:0] e;
        @(negedge clock);
        cyc++;
        if (prev_hold && !prev_sr) begin
            check("hold_valid", m_valid, 1);
            check("hold_head", {m_first, m_last, m_data}, prev_head);
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_with_empty_scoreboard", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("beat", {m_first, m_last, m_data}, e);
            end
            pop_cnt++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
        end
        if (read_enb && first_re_cyc < 0) first_re_cyc = cyc;
        if (dbg_state == S_PLD) saw_pld = 1;
        if (pkt_done) begin
            cnt_done++;
            done_cyc = cyc;
        end
        if (parity_err) cnt_err++;
        if (abort) cnt_abort++;
        mon_valid = m_valid;
        mon_abort = abort;
        prev_hold = m_valid && !m_ready;
        prev_head = {m_first, m_last, m_data};
        prev_sr   = soft_reset || !resetn;
        re_s      = read_enb;
        @(posedge clock);
        #1;
        if (re_s) begin
            if (src_q.size() == 0) check("read_underflow", src_q.size(), 1);
            else data_out = src_q.pop_front();
        end else begin
            data_out = 8'($urandom);
        end
        vld_out = (src_q.size() != 0);
    endtask

    // Packet model: header, len payload bytes, parity = XOR of all preceding bytes.
    task automatic add_pkt(input logic [7:0] hdr, input bit use_par, input logic [7:0] par_in,
                           input bit corrupt);
        logic [7:0] acc;
        logic [7:0] b;
        logic [7:0] par;
        int         len;
        len = int'(hdr[7:2]);
        acc = hdr;
        src_q.push_back(hdr);
        exp_q.push_back({2'b10, hdr});
        for (int i = 0; i < len; i++) begin
            b = (i < pl_q.size()) ? pl_q[i] : 8'($urandom);
            acc ^= b;
            src_q.push_back(b);
            exp_q.push_back({2'b00, b});
        end
        par = use_par ? par_in : (corrupt ? (acc ^ 8'h5A) : acc);
        src_q.push_back(par);
        exp_q.push_back({2'b01, par});
        exp_done++;
        if (par != acc) exp_err++;
        pl_q.delete();
        vld_out = (src_q.size() != 0);
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0) && k < budget) begin
            step();
            k++;
        end
        check(tag, (k < budget), 1);
        repeat (3) step();
    endtask

    task automatic wait_pops(input string tag, input int n);
        int k = 0;
        int base = pop_cnt;
        while ((pop_cnt - base) < n && k < 60) begin
            step();
            k++;
        end
        check(tag, (k < 60), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn     = 1'b0;
        vld_out    = 1'b0;
        data_out   = 8'h00;
        soft_reset = 1'b0;
        m_ready    = 1'b0;

        // Reset values, with the FIFO claiming data to prove no read escapes.
        repeat (3) @(posedge clock);
        #2;
        vld_out = 1'b1;
        #1;
        check("rst_read_enb", read_enb, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_first", m_first, 0);
        check("rst_m_last", m_last, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_pkt_done", pkt_done, 0);
        check("rst_abort", abort, 0);
        check("rst_stall_warn", stall_warn, 0);
        check("rst_state", dbg_state, S_HDR);
        vld_out = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        repeat (2) step();

        // Nominal packet at full rate.
        m_ready = 1'b1;
        mark();
        pl_q = '{8'h11, 8'h22, 8'h33};
        add_pkt(8'h0D, 1, 8'h0D, 0);
        drain("t1_drain", 40);
        check("t1_pops", pop_cnt - base_pop, 5);
        check("t1_back_to_back", last_pop_cyc - first_pop_cyc, 4);
        check("t1_latency", first_pop_cyc - first_re_cyc, 2);
        check("t1_done_with_parity_beat", done_cyc, last_pop_cyc);
        check("t1_pkt_done", cnt_done - base_done, 1);
        check("t1_parity_err", cnt_err - base_err, 0);

        // Same packet with a wrong parity byte.
        mark();
        pl_q = '{8'h11, 8'h22, 8'h33};
        add_pkt(8'h0D, 1, 8'h0C, 0);
        drain("t2_drain", 40);
        check("t2_pops", pop_cnt - base_pop, 5);
        check("t2_pkt_done", cnt_done - base_done, 1);
        check("t2_parity_err", cnt_err - base_err, 1);

        // Zero-length packet skips the payload state.
        mark();
        add_pkt(8'h02, 0, 8'h00, 0);
        drain("t3_drain", 40);
        check("t3_pops", pop_cnt - base_pop, 2);
        check("t3_no_payload_state", saw_pld, 0);
        check("t3_pkt_done", cnt_done - base_done, 1);

        // Long back-pressure mid-payload: reads stop, stall warning rises.
        mark();
        add_pkt(8'h50, 0, 8'h00, 0);
        wait_pops("t4_start", 3);
        m_ready = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k >= 2) check("t4_read_enb_off", re_s, 0);
            if (k == 10) check("t4_no_warn_early", stall_warn, 0);
            if (k == 30) check("t4_warn", stall_warn, 1);
        end
        m_ready = 1'b1;
        repeat (3) step();
        check("t4_warn_clears", stall_warn, 0);
        drain("t4_drain", 60);
        check("t4_pops", pop_cnt - base_pop, 22);
        check("t4_pkt_done", cnt_done - base_done, 1);

        // soft_reset after two payload bytes of a len-5 packet.
        mark();
        add_pkt(8'h14, 0, 8'h00, 0);
        wait_pops("t5_start", 3);
        m_ready    = 1'b0;
        soft_reset = 1'b1;
        src_q.delete();
        exp_q.delete();
        exp_done--;
        vld_out = 1'b0;
        step();
        soft_reset = 1'b0;
        m_ready    = 1'b1;
        step();
        check("t5_abort", mon_abort, 1);
        check("t5_valid_dropped", mon_valid, 0);
        pl_q = '{8'h77};
        add_pkt(8'h05, 1, 8'h72, 0);
        drain("t5_drain", 40);
        check("t5_abort_count", cnt_abort - base_abort, 1);
        check("t5_pkt_done", cnt_done - base_done, 1);
        check("t5_parity_err", cnt_err - base_err, 0);

        // Asynchronous reset mid-payload, then a clean packet.
        mark();
        add_pkt(8'h18, 0, 8'h00, 0);
        wait_pops("t6_start", 3);
        resetn = 1'b0;
        #2;
        check("t6_read_enb", read_enb, 0);
        check("t6_m_valid", m_valid, 0);
        check("t6_m_data", m_data, 0);
        check("t6_m_first", m_first, 0);
        check("t6_m_last", m_last, 0);
        check("t6_pulses", {parity_err, pkt_done, abort, stall_warn}, 0);
        src_q.delete();
        exp_q.delete();
        exp_done--;
        vld_out   = 1'b0;
        prev_hold = 0;
        re_s      = 0;
        @(negedge clock);
        resetn = 1'b1;
        step();
        pl_q = '{8'hAA};
        add_pkt(8'h05, 1, 8'hAF, 0);
        drain("t6_drain", 40);
        check("t6_pkt_done", cnt_done - base_done, 1);
        check("t6_parity_err", cnt_err - base_err, 0);

        // Random packets under random sink back-pressure.
        mark();
        for (int p = 0; p < 30; p++) begin
            add_pkt({6'($urandom_range(0, 10)), 2'($urandom_range(0, 3))}, 0, 8'h00,
                    ($urandom_range(0, 4) == 0));
        end
        begin
            int k = 0;
            while ((exp_q.size() != 0 || src_q.size() != 0) && k < 3000) begin
                m_ready = ($urandom_range(0, 9) < 7);
                step();
                k++;
            end
            check("t7_drain", (k < 3000), 1);
        end
        m_ready = 1'b1;
        repeat (4) step();
        check("total_pkt_done", cnt_done, exp_done);
        check("total_parity_err", cnt_err, exp_err);
        check("total_abort", cnt_abort, 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
